// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and constants for the instruction-memory loader.
package imem_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, ERROR} state_t;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0040_0000;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: valid/ready program-word stream with last flag.
interface imem_loader_if #(parameter int DATA_W = 32);
  logic Load_valid;
  logic Load_ready;
  logic [DATA_W-1:0] Load_data;
  logic Load_last;
  modport master(output Load_valid, Load_data, Load_last, input Load_ready);
  modport slave(input Load_valid, Load_data, Load_last, output Load_ready);
endinterface

// File: rtl/imem_loader_array.sv
// imem_array: DEPTH x DATA_W synchronous RAM, one write port, one registered read port.
module imem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 64,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a program into instruction memory, then releases the core and serves fetches.
// Define IMEM_LOADER_RELOAD_EN to add Reload_req for reprogramming from RUN without a global reset.
module imem_loader import imem_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 64,
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              Clk,
  input  logic              Rst,
  imem_loader_if.slave      ld,
  input  logic [31:0]       Address_from_PC,
  output logic [DATA_W-1:0] Instruction,
  output logic              Core_rst,
  output logic              Load_done,
  output logic              Load_err,
  output logic [ADDR_W:0]   Load_count
`ifdef IMEM_LOADER_RELOAD_EN
  ,
  input  logic              Reload_req
`endif
);
  localparam logic [DATA_W-1:0] NOP = DATA_W'(NOP_INSTR);
  state_t state;
  logic reload, beat, hit, hit_q;
  logic [31:0] idx;
  logic [DATA_W-1:0] rdata;
`ifdef IMEM_LOADER_RELOAD_EN
  assign reload = Reload_req;
`else
  assign reload = 1'b0;
`endif
  assign ld.Load_ready = state == LOAD;
  assign Core_rst = state == RUN;
  assign Load_done = state == RUN;
  assign Load_err = state == ERROR;
  assign beat = ld.Load_valid && ld.Load_ready;
  // addresses below BASE_ADDR wrap to a huge index and miss naturally
  assign idx = (Address_from_PC - BASE_ADDR) >> 2;
  assign hit = state == RUN && !reload && idx < 32'(Load_count);
  assign Instruction = hit_q ? rdata : NOP;
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state <= IDLE;
      Load_count <= '0;
      hit_q <= 1'b0;
    end else begin
      hit_q <= hit;
      case (state)
        IDLE: state <= LOAD;
        LOAD: if (beat) begin
          Load_count <= Load_count + 1'b1;
          state <= ld.Load_last ? RUN :
                   Load_count == (ADDR_W+1)'(DEPTH-1) ? ERROR : LOAD;
        end
        RUN: if (reload) begin
          state <= LOAD;
          Load_count <= '0;
        end
        default: state <= ERROR;
      endcase
    end
  end
  imem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_array (
    .clk(Clk),
    .we(beat),
    .waddr(Load_count[ADDR_W-1:0]),
    .wdata(ld.Load_data),
    .raddr(idx[ADDR_W-1:0]),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader (DEPTH 8); reload test needs IMEM_LOADER_RELOAD_EN.
module tb_imem_loader;
  localparam logic [31:0] BASE = 32'h0040_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 0;
  logic rst;
  logic [31:0] pc;
  logic [31:0] instr;
  logic core_rst, done, err;
  logic [3:0] cnt;
  logic reload;
  int checks = 0;
  int passed = 0;
  logic [31:0] m_mem [8];
  int m_cnt = 0;
  logic [31:0] sb [$];
  imem_loader_if #(.DATA_W(32)) lif ();
  always #5 clk = ~clk;
  imem_loader #(.DATA_W(32), .DEPTH(8), .BASE_ADDR(BASE)) dut (
    .Clk(clk),
    .Rst(rst),
    .ld(lif.slave),
    .Address_from_PC(pc),
    .Instruction(instr),
    .Core_rst(core_rst),
    .Load_done(done),
    .Load_err(err),
    .Load_count(cnt)
`ifdef IMEM_LOADER_RELOAD_EN
    ,
    .Reload_req(reload)
`endif
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] exp_fetch(logic [31:0] a);
    logic [31:0] i;
    i = (a - BASE) >> 2;
    return (i < 32'(m_cnt)) ? m_mem[i[2:0]] : NOP;
  endfunction
  task automatic send(input logic [31:0] d, input logic l);
    lif.Load_valid = 1;
    lif.Load_data = d;
    lif.Load_last = l;
    tick();
    m_mem[m_cnt[2:0]] = d;
    m_cnt++;
    lif.Load_valid = 0;
    lif.Load_last = 0;
  endtask
  task automatic start();
    rst = 0;
    lif.Load_valid = 0;
    lif.Load_last = 0;
    tick();
    m_cnt = 0;
    rst = 1;
    tick();
  endtask
  task automatic test_reset();
    rst = 0;
    lif.Load_valid = 0;
    lif.Load_last = 0;
    pc = BASE;
    tick();
    tick();
    m_cnt = 0;
    checks++; if (lif.Load_ready !== 1'b0) $display("FAIL reset_ready got %b exp 0", lif.Load_ready); else passed++;
    checks++; if (instr !== NOP) $display("FAIL reset_instr got %h exp %h", instr, NOP); else passed++;
    checks++; if ({core_rst, done, err} !== 3'b000) $display("FAIL reset_flags got %b exp 000", {core_rst, done, err}); else passed++;
    checks++; if (cnt !== 4'd0) $display("FAIL reset_count got %0d exp 0", cnt); else passed++;
    rst = 1;
    lif.Load_valid = 1;
    lif.Load_data = 32'hDEAD_BEEF;
    #1;
    checks++; if (lif.Load_ready !== 1'b0) $display("FAIL idle_ready got %b exp 0", lif.Load_ready); else passed++;
    tick();
    lif.Load_valid = 0;
    checks++; if (cnt !== 4'd0) $display("FAIL idle_valid_ignored got %0d exp 0", cnt); else passed++;
    checks++; if (lif.Load_ready !== 1'b1) $display("FAIL load_ready got %b exp 1", lif.Load_ready); else passed++;
  endtask
  task automatic test_load4();
    logic [31:0] prog [4] = '{32'h0050_0093, 32'h0010_0113, 32'h0020_81B3, 32'h0000_006F};
    for (int i = 0; i < 4; i++) begin
      checks++; if (core_rst !== 1'b0) $display("FAIL load4_core_rst_early got %b exp 0 at %0d", core_rst, i); else passed++;
      send(prog[i], i == 3);
    end
    checks++; if (cnt !== 4'd4) $display("FAIL load4_count got %0d exp 4", cnt); else passed++;
    checks++; if ({core_rst, done, lif.Load_ready} !== 3'b110) $display("FAIL load4_run_flags got %b exp 110", {core_rst, done, lif.Load_ready}); else passed++;
    checks++; if (instr !== NOP) $display("FAIL load4_instr_nop got %h exp %h", instr, NOP); else passed++;
  endtask
  task automatic test_fetch();
    logic [31:0] addrs [7] = '{32'h0040_0008, 32'h0040_0010, 32'h003F_FFFC, 32'h0040_0000,
                               32'h0040_000E, 32'h0040_0004, 32'hFFFF_FFFF};
    logic [31:0] e;
    for (int i = 0; i < 7; i++) begin
      pc = addrs[i];
      sb.push_back(exp_fetch(addrs[i]));
      tick();
      e = sb.pop_front();
      checks++; if (instr !== e) $display("FAIL fetch pc=%h got %h exp %h", addrs[i], instr, e); else passed++;
    end
    lif.Load_valid = 1;
    tick();
    lif.Load_valid = 0;
    checks++; if (cnt !== 4'd4) $display("FAIL run_valid_ignored got %0d exp 4", cnt); else passed++;
  endtask
  task automatic test_backpressure();
    start();
    for (int i = 0; i < 6; i++) begin
      lif.Load_valid = (i % 2) == 0;
      lif.Load_data = 32'h100 + i;
      lif.Load_last = (i == 4) || (i == 5);
      tick();
      if ((i % 2) == 0) begin
        m_mem[m_cnt[2:0]] = 32'h100 + i;
        m_cnt++;
      end
      checks++; if (cnt !== 4'(m_cnt)) $display("FAIL bp_count step %0d got %0d exp %0d", i, cnt, m_cnt); else passed++;
    end
    lif.Load_valid = 0;
    lif.Load_last = 0;
    checks++; if (done !== 1'b1) $display("FAIL bp_done got %b exp 1", done); else passed++;
    for (int i = 0; i < 4; i++) begin
      pc = BASE + 32'(i * 4);
      sb.push_back(exp_fetch(pc));
      tick();
      checks++; if (instr !== sb[0]) $display("FAIL bp_fetch idx %0d got %h exp %h", i, instr, sb[0]); else passed++;
      void'(sb.pop_front());
    end
  endtask
  task automatic test_overflow();
    start();
    for (int i = 0; i < 8; i++) begin
      checks++; if (err !== 1'b0) $display("FAIL ovf_err_early got %b exp 0 at %0d", err, i); else passed++;
      send(32'hA000 + i, 1'b0);
    end
    checks++; if ({err, core_rst, lif.Load_ready} !== 3'b100) $display("FAIL ovf_flags got %b exp 100", {err, core_rst, lif.Load_ready}); else passed++;
    checks++; if (cnt !== 4'd8) $display("FAIL ovf_count got %0d exp 8", cnt); else passed++;
    lif.Load_valid = 1;
    lif.Load_data = 32'hBAD;
    pc = BASE;
    tick();
    tick();
    lif.Load_valid = 0;
    checks++; if (cnt !== 4'd8 || err !== 1'b1) $display("FAIL ovf_ninth got cnt %0d err %b exp 8 1", cnt, err); else passed++;
    checks++; if (instr !== NOP) $display("FAIL ovf_instr got %h exp %h", instr, NOP); else passed++;
  endtask
  task automatic test_abort();
    start();
    send(32'h11, 0);
    send(32'h22, 0);
    rst = 0;
    tick();
    m_cnt = 0;
    checks++; if (cnt !== 4'd0) $display("FAIL abort_count got %0d exp 0", cnt); else passed++;
    checks++; if ({lif.Load_ready, done, err, core_rst} !== 4'b0000) $display("FAIL abort_idle got %b exp 0000", {lif.Load_ready, done, err, core_rst}); else passed++;
    rst = 1;
    tick();
    for (int i = 0; i < 5; i++) send(32'h0C00_0000 + 32'(i * 7), i == 4);
    checks++; if (cnt !== 4'd5 || done !== 1'b1) $display("FAIL abort_reload got cnt %0d done %b exp 5 1", cnt, done); else passed++;
    for (int i = 0; i < 6; i++) begin
      pc = BASE + 32'(i * 4);
      sb.push_back(exp_fetch(pc));
      tick();
      checks++; if (instr !== sb[0]) $display("FAIL abort_fetch idx %0d got %h exp %h", i, instr, sb[0]); else passed++;
      void'(sb.pop_front());
    end
  endtask
`ifdef IMEM_LOADER_RELOAD_EN
  task automatic test_reload();
    reload = 1;
    tick();
    reload = 0;
    m_cnt = 0;
    checks++; if ({core_rst, lif.Load_ready} !== 2'b01) $display("FAIL reload_flags got %b exp 01", {core_rst, lif.Load_ready}); else passed++;
    checks++; if (cnt !== 4'd0 || instr !== NOP) $display("FAIL reload_clear got cnt %0d instr %h", cnt, instr); else passed++;
    send(32'h0000_1111, 0);
    send(32'h0000_2222, 1);
    checks++; if (core_rst !== 1'b1) $display("FAIL reload_run got %b exp 1", core_rst); else passed++;
    for (int i = 0; i < 3; i++) begin
      pc = BASE + 32'(i * 4);
      sb.push_back(exp_fetch(pc));
      tick();
      checks++; if (instr !== sb[0]) $display("FAIL reload_fetch idx %0d got %h exp %h", i, instr, sb[0]); else passed++;
      void'(sb.pop_front());
    end
  endtask
`endif
  initial begin
    reload = 0;
    lif.Load_data = 0;
    test_reset();
    test_load4();
    test_fetch();
`ifdef IMEM_LOADER_RELOAD_EN
    test_reload();
`endif
    test_backpressure();
    test_overflow();
    test_abort();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Parametrised instruction-memory subsystem with a streaming program loader. It accepts program words over a valid/ready stream terminated by a last flag and stores them in a synchronous word array. It then releases the processor from reset and serves instruction fetches addressed by the program counter. It sits between the file-reading stimulus source and the RISC-V lite core, replacing the fixed 32-word instruction memory and its write-on-EOF coupling.

## Interface

Parameters:
- DATA_W, 32: instruction word width.
- DEPTH, 64: number of words. Power of two, at least 2. ADDR_W = clog2(DEPTH).
- BASE_ADDR, 32'h0040_0000: byte address of word 0 as seen on Address_from_PC.

Ports:
- Clk  in  1  single clock; all state updates on the rising edge.
- Rst  in  1  synchronous, active-low reset.
- Load_valid  in  1  source presents Load_data.
- Load_ready  out  1  loader accepts a word this cycle.
- Load_data  in  DATA_W  program word.
- Load_last  in  1  qualifies the final word of the program.
- Address_from_PC  in  32  byte fetch address.
- Instruction  out  DATA_W  fetched word, registered.
- Core_rst  out  1  active-low reset to the processor; low until the program is loaded.
- Load_done  out  1  high in RUN.
- Load_err  out  1  sticky overflow flag.
- Load_count  out  ADDR_W+1  number of words stored.

## Operation

- States: IDLE, LOAD, RUN, ERROR. Rst low forces IDLE and Load_count = 0. Memory contents are not cleared.
- IDLE -> LOAD unconditionally on the first edge with Rst high.
- LOAD:
  - Load_ready = 1.
  - A beat is the cycle with Load_valid & Load_ready. It writes Load_data to word Load_count, then Load_count increments.
  - A beat with Load_last = 1 -> RUN.
  - A beat at Load_count = DEPTH-1 with Load_last = 0 -> ERROR. The word is still written.
- RUN:
  - Load_ready = 0, Load_done = 1, Core_rst = 1.
  - Fetch index idx = (Address_from_PC - BASE_ADDR) >> 2, computed in 32-bit modular arithmetic.
  - The two LSBs of Address_from_PC are ignored.
  - If idx < Load_count, Instruction <= mem[idx]. Otherwise Instruction <= NOP (32'h0000_0013, zero-extended or truncated to DATA_W). This covers addresses below BASE_ADDR, which wrap to a large idx.
- ERROR:
  - Load_err = 1, Load_ready = 0, Core_rst = 0. Instruction holds NOP.
  - Leaves ERROR only on reset.
- Outside RUN, Instruction is NOP and fetch addresses are ignored.
- Load_ready, Load_done, Load_err and Core_rst are Moore outputs decoded from registered state.

## Timing

- Reset values: Load_ready 0, Instruction NOP, Core_rst 0, Load_done 0, Load_err 0, Load_count 0.
- Load_ready rises one cycle after Rst deasserts (the IDLE cycle).
- Sustained throughput: one word per cycle.
- The last beat at edge N gives state RUN after edge N, so Core_rst and Load_done are high in cycle N+1.
- Fetch latency is 1 cycle. An address presented before edge K gives Instruction valid after edge K.
- A word written at edge N is readable by a fetch at edge N+1 or later. No write/read collision is possible because writes occur only in LOAD.
- Load_valid while Load_ready = 0 is ignored; no beat occurs.
- Load_last without Load_valid is ignored.
- Rst low mid-load aborts the load on the next edge: count returns to 0 and the full reload restarts via IDLE.

## Configuration

- IMEM_LOADER_RELOAD_EN defined:
  - Adds input Reload_req (1 bit).
  - In RUN, Reload_req = 1 -> LOAD on the next edge, with Load_count cleared, Core_rst = 0 and Instruction = NOP.
  - Gives in-system reprogramming without a global reset.
- Undefined: the port does not exist, and RUN is terminal until reset.

## Structure

- Package imem_pkg:
  - state enum (IDLE, LOAD, RUN, ERROR).
  - NOP_INSTR constant.
  - default BASE_ADDR constant.
- Sub-module imem_array:
  - DEPTH x DATA_W synchronous RAM: one write port and one registered read port, no reset on storage.
  - Selecting between NOP and memory data stays in imem_loader.

## Test plan

- Reset, then stream 4 words 0x00500093, 0x00100113, 0x002081B3, 0x0000006F with Load_last on the 4th:
  - Load_count = 4.
  - Core_rst and Load_done rise the cycle after the 4th beat.
- Fetch after load:
  - PC = 0x00400008 -> Instruction = 0x002081B3 one cycle later.
  - PC = 0x00400010 -> NOP.
  - PC = 0x003FFFFC -> NOP.
- Backpressure and spacing:
  - Load_valid toggled every other cycle, 3 words: exactly 3 beats and Load_count = 3.
  - Load_valid during IDLE: not accepted.
- DEPTH = 8, 8 words with no Load_last:
  - After the 8th beat: Load_err = 1, Core_rst = 0, Load_ready = 0.
  - A 9th word is not accepted.
- Rst pulsed low after 2 of 5 words:
  - Load_count = 0 and state IDLE.
  - A fresh 5-word load then completes normally.
- IMEM_LOADER_RELOAD_EN build, Reload_req in RUN:
  - Core_rst drops the next cycle.
  - A new 2-word program reads back correctly.
  - PC = BASE_ADDR + 8 returns NOP.
